// File: rtl/spi_wishbone_burst_bridge.sv
// SPI-slave (mode 0) to Wishbone-master bridge with auto-incrementing bursts,
// per-word poll/start/status handshake on MISO and a bus timeout.
module spi_wishbone_burst_bridge #(
  parameter int unsigned ADDR_WIDTH     = 23,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_sck,
  input  logic                  spi_ss_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic                  rty_i,
  input  logic [DATA_WIDTH-1:0] dat_i
);

  localparam int unsigned HDR_BITS = 8 * ((ADDR_WIDTH + 8) / 8);
  localparam int unsigned CNT_MAX  = (HDR_BITS > DATA_WIDTH) ? HDR_BITS : DATA_WIDTH;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX);
  localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_WDATA,
    ST_RESP,
    ST_STATUS,
    ST_RDATA
  } state_t;

  logic [2:0] sck_q;
  logic [1:0] ss_q;
  logic [1:0] mosi_q;

  state_t                state_q, state_d;
  logic [HDR_BITS-2:0]   hdr_q, hdr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cyc_q, cyc_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  pend_q, pend_d;
  logic                  miso_q, miso_d;

  logic                  spi_edge;
  logic                  mosi_s;
  logic [HDR_BITS-1:0]   hdr_full;
  logic                  tmo_hit;
  logic                  bus_err;

  assign spi_edge = sck_q[1] & ~sck_q[2];
  assign mosi_s   = mosi_q[1];
  assign hdr_full = {hdr_q, mosi_s};
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign bus_err  = err_i | rty_i | (tmo_hit & ~ack_i);

  // Two-flop synchronisers; sck_q[2] is the previous synchronised sck for edge detect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q  <= 3'b000;
      ss_q   <= 2'b11;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      ss_q   <= {ss_q[0], spi_ss_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || ss_q[1]) begin
      state_q <= ST_HEADER;
      hdr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      miso_q  <= miso_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    done_d  = done_q;
    pend_d  = pend_q;
    miso_d  = miso_q;

    // Bus termination: error inputs win over ack, any handshake wins over timeout.
    if (cyc_q) begin
      tmo_d = tmo_q + 1'b1;
      if (ack_i || err_i || rty_i || tmo_hit) begin
        cyc_d  = 1'b0;
        done_d = 1'b1;
        err_d  = bus_err;
        if (!we_q) rdata_d = bus_err ? '0 : dat_i;
      end
    end

    if (spi_edge) begin
      case (state_q)
        ST_HEADER: begin
          hdr_d = hdr_full[HDR_BITS-2:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(HDR_BITS - 1)) begin
            cnt_d = '0;
            we_d  = hdr_full[HDR_BITS-1];
            adr_d = hdr_full[ADDR_WIDTH-1:0];
            if (hdr_full[HDR_BITS-1]) begin
              state_d = ST_WDATA;
            end else begin
              cyc_d   = 1'b1;
              tmo_d   = '0;
              done_d  = 1'b0;
              state_d = ST_RESP;
            end
          end
        end
        ST_WDATA: begin
          dat_d = {dat_q[DATA_WIDTH-2:0], mosi_s};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            cyc_d   = 1'b1;
            tmo_d   = '0;
            done_d  = 1'b0;
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          if (done_q) begin
            miso_d  = 1'b1;
            state_d = ST_STATUS;
          end else begin
            miso_d = 1'b0;
            // A continued read burst launches its bus cycle on the first poll.
            if (pend_q) begin
              pend_d = 1'b0;
              cyc_d  = 1'b1;
              tmo_d  = '0;
              done_d = 1'b0;
            end
          end
        end
        ST_STATUS: begin
          miso_d = err_q;
          cnt_d  = '0;
          if (we_q) begin
            adr_d   = adr_q + 1'b1;
            state_d = ST_WDATA;
          end else begin
            state_d = ST_RDATA;
          end
        end
        ST_RDATA: begin
          miso_d  = rdata_q[DATA_WIDTH-1];
          rdata_d = rdata_q << 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            adr_d   = adr_q + 1'b1;
            pend_d  = 1'b1;
            done_d  = 1'b0;
            state_d = ST_RESP;
          end
        end
        default: state_d = ST_HEADER;
      endcase
    end
  end

  assign spi_miso = miso_q;
  assign cyc_o    = cyc_q;
  assign stb_o    = cyc_q;
  assign we_o     = we_q;
  assign adr_o    = adr_q;
  assign dat_o    = dat_q;

endmodule

// File: doc/spi_wishbone_burst_bridge.md
Name: spi_wishbone_burst_bridge

Overview:
SPI-slave to Wishbone-master bridge with parametrised address and data widths, auto-incrementing burst reads and writes, and a per-word completion/status handshake on MISO. A Wishbone timeout guards against silent slaves. It is the host access path into the on-chip Wishbone bus and generalises the single-byte SPI bridge.

Parameters:
ADDR_WIDTH, 23, Wishbone address width (1..31).
DATA_WIDTH, 8, Wishbone data width (multiple of 8, 8..32).
TIMEOUT_CYCLES, 255, clk_i cycles with cyc_o high before a forced error termination; 0 disables the timeout.

Ports:
clk_i  in  1  system clock, the only clock
rst_i  in  1  synchronous active-high reset
spi_sck  in  1  SPI clock, asynchronous, mode 0
spi_ss_n  in  1  SPI select, active low, asynchronous
spi_mosi  in  1  SPI data in
spi_miso  out  1  SPI data out
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe, always equal to cyc_o
we_o  out  1  write enable
adr_o  out  ADDR_WIDTH  word address
dat_o  out  DATA_WIDTH  write data
ack_i  in  1  Wishbone acknowledge
err_i  in  1  Wishbone error
rty_i  in  1  Wishbone retry, treated as an error
dat_i  in  DATA_WIDTH  read data

Behaviour:
- Synchronisation: sck, ss_n and mosi each pass through a 2-flop synchroniser. An SPI edge is a detected 0->1 transition of the synchronised sck. MOSI is sampled on that edge. MISO changes only on that edge.
- Reset: rst_i or synchronised ss_n high clears, on the next clk_i edge, all of: miso=0, cyc_o=0, we_o=0, adr_o=0, dat_o=0, counters=0, error/timeout state, and the FSM (to HEADER).
  - Deselecting mid-cycle aborts the bus cycle by dropping cyc_o.
- HDR_BITS = 8*ceil((1+ADDR_WIDTH)/8). The header is shifted MSB-first. Bit HDR_BITS-1 is we. The low ADDR_WIDTH bits are the start address. Pad bits are ignored.
- States:
  - HEADER: shift HDR_BITS bits. On the last bit, latch we_o/adr_o.
    - Read: assert cyc_o on the same clk_i cycle, go RESP.
    - Write: go WDATA.
  - WDATA: shift DATA_WIDTH bits MSB-first into dat_o. On the last bit, assert cyc_o and go RESP. dat_o is held stable while cyc_o is high.
  - RESP (poll): each SPI edge drives MISO=0 while the bus result is not yet latched. The first SPI edge after the result is latched drives MISO=1 (start bit) and goes STATUS. MOSI is ignored.
  - STATUS: the SPI edge drives MISO=error flag.
    - Write: increment adr_o, go WDATA.
    - Read: go RDATA.
  - RDATA: DATA_WIDTH SPI edges shift the latched read word out MSB-first. After the last bit, increment adr_o and go RESP with read-pending set.
    - The first SPI edge in RESP asserts cyc_o for the next read and drives MISO=0.
    - No bus read is issued unless the master continues clocking after the last bit.
- Bus termination: while cyc_o is high, the first clk_i cycle with ack_i, err_i, rty_i or timeout does all of:
  - drops cyc_o in the next cycle;
  - latches dat_i (reads);
  - latches error = err_i|rty_i|timeout.
  - Priority: err_i/rty_i over ack_i, and any handshake input over timeout in the same cycle.
  - On error, the latched read data is forced to 0.
- Timeout: counts clk_i cycles with cyc_o high. When the count reaches TIMEOUT_CYCLES, the cycle terminates with error. The counter clears on every new cycle.
- Address increments by 1 per word and wraps modulo 2^ADDR_WIDTH (all-ones -> 0).
- Handshake inputs are ignored while cyc_o is low.
- SPI edges arriving while cyc_o is high in RESP only produce MISO=0 polls. They are never lost or miscounted.

Test Plan:
- Single read, addr 0x000010, slave acks after 3 clk with dat_i=0xA5 -> MISO shows 0s, then 1, 0, 10100101. Exactly one cycle, adr_o=0x000010, we_o=0.
- Burst write, addr 0x7FFFFF, data 0x11,0x22 with slave ack -> writes to 0x7FFFFF then 0x000000 (wrap). Each word is followed by poll 0s, start 1, status 0.
- Burst read of 3 words then ss_n high -> exactly 3 bus reads to addr, addr+1, addr+2. No fourth cycle is issued.
- Slave never responds, TIMEOUT_CYCLES=255 -> cyc_o drops after 255 cycles. MISO gives start 1, status 1, data 0x00.
- err_i and ack_i in the same cycle on a write -> status bit 1. rty_i on a read -> status 1, data 0x00.
- ss_n deasserted while cyc_o is high, and rst_i pulsed mid-header -> cyc_o low within 3 clk. The next transaction decodes a fresh header correctly.
